// File: rtl/mdu_unit_pkg.sv
// ============================================================================
// Module : mdu_unit_pkg
// Brief  : Op codes and decode helpers shared by the multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_unit_pkg;

  localparam logic [5:0] OP_MULT  = 6'b100010;
  localparam logic [5:0] OP_MULTU = 6'b100011;
  localparam logic [5:0] OP_DIV   = 6'b100100;
  localparam logic [5:0] OP_DIVU  = 6'b100101;
  localparam logic [5:0] OP_MFHI  = 6'b100110;
  localparam logic [5:0] OP_MFLO  = 6'b100111;
  localparam logic [5:0] OP_MTHI  = 6'b101000;
  localparam logic [5:0] OP_MTLO  = 6'b101001;

  function automatic logic is_md_start(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
// Module : mdu_calc
// Brief  : Combinational 64-bit multiply / 32-bit divide producing {hi,lo}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    w_prod_u = {32'b0, a} * {32'b0, b};
    w_neg_a  = (op == OP_DIV) && a[31];
    w_neg_b  = (op == OP_DIV) && b[31];
    w_mag_a  = w_neg_a ? (~a + 32'd1) : a;
    w_mag_b  = w_neg_b ? (~b + 32'd1) : b;
    w_den    = (b == 32'd0) ? 32'd1 : w_mag_b;
    w_q      = w_mag_a / w_den;
    w_r      = w_mag_a % w_den;
    w_quo    = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
    w_rem    = w_neg_a ? (~w_r + 32'd1) : w_r;
    div0     = is_div(op) && (b == 32'd0);

    hi = 32'd0;
    lo = 32'd0;
    case (op)
      OP_MULT:          {hi, lo} = w_prod_s;
      OP_MULTU:         {hi, lo} = w_prod_u;
      OP_DIV, OP_DIVU: begin
        hi = w_rem;
        lo = w_quo;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// Module : mdu_unit
// Brief  : EX-stage multiply/divide unit owning HI/LO with modelled latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [5:0]  op_type,   // "type" is reserved in SystemVerilog
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] c_mul_lat = CW'(MUL_LAT);
  localparam logic [CW-1:0] c_div_lat = CW'(DIV_LAT);
  localparam logic [CW-1:0] c_one     = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_wr;

  logic [31:0]   w_hi;
  logic [31:0]   w_lo;
  logic          w_div0;
  logic          w_issue;

  mdu_calc u_calc (
    .op   (op_type),
    .a    (in1),
    .b    (in2),
    .hi   (w_hi),
    .lo   (w_lo),
    .div0 (w_div0)
  );

  assign start   = en && is_md_start(op_type);
  assign busy    = (r_cnt != '0);
  assign w_issue = start && !busy;

  // Commit is written after MT so a stray MT during an in-flight op is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      if (w_issue) begin
        r_cnt     <= is_div(op_type) ? c_div_lat : c_mul_lat;
        r_pend_hi <= w_hi;
        r_pend_lo <= w_lo;
        r_pend_wr <= !w_div0;
      end else if (busy) begin
        r_cnt <= r_cnt - c_one;
      end
      if (en && (op_type == OP_MTHI)) r_hi <= in1;
      if (en && (op_type == OP_MTLO)) r_lo <= in1;
      if ((r_cnt == c_one) && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  always_comb begin
    out = 32'd0;
    if (en && (op_type == OP_MFHI)) out = r_hi;
    if (en && (op_type == OP_MFLO)) out = r_lo;
  end

endmodule

`default_nettype wire
